// File: rtl/alu_issue_stage_if.sv
// Bundle between ID, the ALU issue stage and EX/MEM: instruction/operand input, ALU-facing output, writeback bypass.
// Latency: none, wires only.
// Backpressure: in_ready is returned to ID, and out_ready is returned from EX/MEM.
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            alu_func;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_wb_en;
  logic                  out_illegal;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  // The issue stage itself.
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, alu_func, alu_op1, alu_op2, out_rd, out_wb_en, out_illegal
  );

  // The surrounding pipeline (ID, register file, EX/MEM).
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, alu_func, alu_op1, alu_op2, out_rd, out_wb_en, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ID/EX issue stage that decodes an instruction into an ALU func code and registers op1/op2; writeback bypass under ALU_ISSUE_BYPASS_EN.
// Latency: 1 cycle from capture to out_valid, with full throughput.
// Backpressure: in_ready = !out_valid || out_ready, outputs are held while stalled, and flush drops both the held and the incoming op.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);

  localparam logic [3:0] FN_ZERO = 4'd0;
  localparam logic [3:0] FN_ADD  = 4'd1;
  localparam logic [3:0] FN_SUB  = 4'd2;
  localparam logic [3:0] FN_SLL  = 4'd3;
  localparam logic [3:0] FN_SLT  = 4'd4;
  localparam logic [3:0] FN_XOR  = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_AND  = 4'd7;
  localparam logic [3:0] FN_SRL  = 4'd8;
  localparam logic [3:0] FN_SRA  = 4'd9;
  localparam logic [3:0] FN_SLTU = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 to ALU code. alt (instr[30]) selects SUB/SRA where it is meaningful.
  function automatic logic [3:0] f3_func(input logic [2:0] f3, input logic alt);
    logic [3:0] fn;
    fn = FN_ZERO;
    case (f3)
      3'b000:  fn = alt ? FN_SUB : FN_ADD;
      3'b001:  fn = FN_SLL;
      3'b010:  fn = FN_SLT;
      3'b011:  fn = FN_SLTU;
      3'b100:  fn = FN_XOR;
      3'b101:  fn = alt ? FN_SRA : FN_SRL;
      3'b110:  fn = FN_OR;
      default: fn = FN_AND;
    endcase
    return fn;
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;
  logic                  op_legal;
  logic                  opimm_legal;
  logic                  opimm_shift;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign rd_idx = REG_ADDR_W'(bus.instr[11:7]);
  assign imm_i  = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u  = DATA_WIDTH'({bus.instr[31:12], 12'b0});
  assign shamt  = DATA_WIDTH'(bus.instr[24:20]);

  // Only SUB and SRA may carry the alternate funct7; everything else needs zero.
  assign op_legal    = (funct7 == F7_ZERO) ||
                       ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign opimm_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign opimm_legal = (funct3 == 3'b001) ? (funct7 == F7_ZERO) :
                       (funct3 == 3'b101) ? ((funct7 == F7_ZERO) || (funct7 == F7_ALT)) : 1'b1;

  logic [3:0]            dec_func;
  logic [DATA_WIDTH-1:0] dec_op1;
  logic [DATA_WIDTH-1:0] dec_op2;
  logic                  dec_ill;
  logic                  dec_wb_base;
  logic                  dec_rs1_src;
  logic                  dec_rs2_src;

  // Combinational decode of the offered instruction; anything unmatched stays illegal with zero operands.
  always_comb begin
    dec_func    = FN_ZERO;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_ill     = 1'b1;
    dec_wb_base = 1'b0;
    dec_rs1_src = 1'b0;
    dec_rs2_src = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (op_legal) begin
          dec_ill     = 1'b0;
          dec_func    = f3_func(funct3, bus.instr[30]);
          dec_op1     = bus.rs1_data;
          dec_op2     = bus.rs2_data;
          dec_wb_base = 1'b1;
          dec_rs1_src = 1'b1;
          dec_rs2_src = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (opimm_legal) begin
          dec_ill     = 1'b0;
          dec_func    = (funct3 == 3'b000) ? FN_ADD : f3_func(funct3, bus.instr[30]);
          dec_op1     = bus.rs1_data;
          dec_op2     = opimm_shift ? shamt : imm_i;
          dec_wb_base = 1'b1;
          dec_rs1_src = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_ill     = 1'b0;
        dec_func    = FN_ADD;
        dec_op2     = imm_u;
        dec_wb_base = 1'b1;
      end
      OPC_AUIPC: begin
        dec_ill     = 1'b0;
        dec_func    = FN_ADD;
        dec_op1     = bus.pc;
        dec_op2     = imm_u;
        dec_wb_base = 1'b1;
      end
      OPC_LOAD: begin
        dec_ill     = 1'b0;
        dec_func    = FN_ADD;
        dec_op1     = bus.rs1_data;
        dec_op2     = imm_i;
        dec_wb_base = 1'b1;
        dec_rs1_src = 1'b1;
      end
      OPC_STORE: begin
        dec_ill     = 1'b0;
        dec_func    = FN_ADD;
        dec_op1     = bus.rs1_data;
        dec_op2     = imm_s;
        dec_rs1_src = 1'b1;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  logic                  vld_q, vld_d;
  logic [3:0]            func_q, func_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wb_en_q, wb_en_d;
  logic                  ill_q, ill_d;
  logic                  capture;
  logic [DATA_WIDTH-1:0] cap_op1;
  logic [DATA_WIDTH-1:0] cap_op2;

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef ALU_ISSUE_BYPASS_EN
  logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx;
  logic [REG_ADDR_W-1:0] rs1_idx_q, rs1_idx_d;
  logic [REG_ADDR_W-1:0] rs2_idx_q, rs2_idx_d;
  logic                  rs1_src_q, rs1_src_d;
  logic                  rs2_src_q, rs2_src_d;
  logic                  wb_live;
  logic                  hold_hit1, hold_hit2;

  assign rs1_idx   = REG_ADDR_W'(bus.instr[19:15]);
  assign rs2_idx   = REG_ADDR_W'(bus.instr[24:20]);
  // x0 is never written, so a writeback to it must not leak into an operand.
  assign wb_live   = bus.wb_en && (bus.wb_rd != '0);
  assign cap_op1   = (wb_live && dec_rs1_src && (bus.wb_rd == rs1_idx)) ? bus.wb_data : dec_op1;
  assign cap_op2   = (wb_live && dec_rs2_src && (bus.wb_rd == rs2_idx)) ? bus.wb_data : dec_op2;
  assign hold_hit1 = wb_live && rs1_src_q && (bus.wb_rd == rs1_idx_q);
  assign hold_hit2 = wb_live && rs2_src_q && (bus.wb_rd == rs2_idx_q);
`else
  logic unused_wb;

  assign cap_op1   = dec_op1;
  assign cap_op2   = dec_op2;
  assign unused_wb = ^{bus.wb_en, bus.wb_rd, bus.wb_data, bus.instr[19:15]};
`endif

  // Next state: flush beats capture, capture beats drain, and a stalled op only changes via the bypass.
  always_comb begin
    vld_d   = vld_q;
    func_d  = func_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    wb_en_d = wb_en_q;
    ill_d   = ill_q;
`ifdef ALU_ISSUE_BYPASS_EN
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    rs1_src_d = rs1_src_q;
    rs2_src_d = rs2_src_q;
`endif
    if (bus.flush) begin
      vld_d = 1'b0;
      ill_d = 1'b0;
    end else if (capture) begin
      vld_d   = 1'b1;
      func_d  = dec_func;
      op1_d   = cap_op1;
      op2_d   = cap_op2;
      rd_d    = dec_ill ? '0 : rd_idx;
      wb_en_d = dec_wb_base && (rd_idx != '0);
      ill_d   = dec_ill;
`ifdef ALU_ISSUE_BYPASS_EN
      rs1_idx_d = rs1_idx;
      rs2_idx_d = rs2_idx;
      rs1_src_d = dec_rs1_src;
      rs2_src_d = dec_rs2_src;
`endif
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
`ifdef ALU_ISSUE_BYPASS_EN
    else if (vld_q) begin
      if (hold_hit1) op1_d = bus.wb_data;
      if (hold_hit2) op2_d = bus.wb_data;
    end
`endif
  end

  // Output and bookkeeping registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      func_q  <= FN_ZERO;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rs1_src_q <= 1'b0;
      rs2_src_q <= 1'b0;
`endif
    end else begin
      vld_q   <= vld_d;
      func_q  <= func_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      wb_en_q <= wb_en_d;
      ill_q   <= ill_d;
`ifdef ALU_ISSUE_BYPASS_EN
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      rs1_src_q <= rs1_src_d;
      rs2_src_q <= rs2_src_d;
`endif
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.alu_func    = func_q;
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wb_en   = wb_en_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode table, stall, flush, async reset, bypass, random traffic.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge after the capturing rising edge.
// The reference model is an instruction-level decoder plus a one-entry holding-register model.
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [3:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_issue_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) bus ();

  alu_issue_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs_now();
    return {bus.alu_func, bus.alu_op1, bus.alu_op2, bus.out_rd, bus.out_wb_en, bus.out_illegal};
  endfunction

  // Instruction-level reference: SUB/SRA are the ADD/SRL codes plus one when funct7 is 0100000.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [3:0]  ftab [0:7];
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] iimm, simm, uimm;
    logic        ok;
    ftab = '{4'd1, 4'd3, 4'd4, 4'd10, 4'd5, 4'd8, 4'd6, 4'd7};
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    iimm = 32'($signed(ins[31:20]));
    simm = 32'($signed({ins[31:25], ins[11:7]}));
    uimm = {ins[31:12], 12'h000};
    e = '0;
    e.ill = 1'b1;
    case (opc)
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.ill = 0; e.func = ftab[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
        e.op1 = r1; e.op2 = r2; e.wb = 1;
      end
      7'h13: begin
        ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        if (ok) begin
          e.ill  = 0;
          e.func = (f3 == 3'd0) ? 4'd1 : ftab[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 4'd1 : 4'd0);
          e.op1  = r1;
          e.op2  = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : iimm;
          e.wb   = 1;
        end
      end
      7'h37: begin e.ill = 0; e.func = 1; e.op1 = 0;   e.op2 = uimm; e.wb = 1; end
      7'h17: begin e.ill = 0; e.func = 1; e.op1 = pcv; e.op2 = uimm; e.wb = 1; end
      7'h03: begin e.ill = 0; e.func = 1; e.op1 = r1;  e.op2 = iimm; e.wb = 1; end
      7'h23: begin e.ill = 0; e.func = 1; e.op1 = r1;  e.op2 = simm; e.wb = 0; end
      default: e.ill = 1;
    endcase
    if (!e.ill) e.rd = ins[11:7];
    if (ins[11:7] == 5'd0) e.wb = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [0:7];
    logic [31:0] ins;
    int          s;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7F, 7'h33};
    ins = $urandom;
    ins[6:0] = opcs[$urandom_range(0, 7)];
    s = $urandom_range(0, 3);
    if (s == 0 || s == 3) ins[31:25] = 7'h00;
    else if (s == 1)      ins[31:25] = 7'h20;
    if ($urandom_range(0, 15) == 0) ins[6:0] = 7'($urandom);
    return ins;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = v;
    bus.instr    = ins;
    bus.pc       = pcv;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  task automatic test_reset();
    exp_t zero;
    zero = '0;
    drive(0, 0, 0, 0, 0);
    bus.flush = 0; bus.out_ready = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (obs_now() !== zero) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs_now(), zero); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed decode vectors, offered back to back with out_ready held high.
  task automatic test_back_to_back();
    logic [31:0] t_ins [0:11];
    logic [31:0] t_r1  [0:11];
    logic [31:0] t_r2  [0:11];
    logic [31:0] t_pc  [0:11];
    exp_t        t_exp [0:11];
    t_ins = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h123450B7, 32'h0000007F, 32'h00001117,
              32'h0020A423, 32'hFFF00013, 32'h022081B3, 32'h002081B0, 32'h60335293, 32'h40014093};
    t_r1  = '{32'd5, 32'd9, 32'h80000000, 32'd77, 32'd1, 32'd3, 32'h100, 32'h55, 32'd1, 32'd1, 32'd8, 32'hA0};
    t_r2  = '{32'd7, 32'd4, 32'd99, 32'd88, 32'd2, 32'd4, 32'h44, 32'h66, 32'd2, 32'd2, 32'd9, 32'hB0};
    t_pc  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    t_exp[0]  = {4'd1,  32'd5,          32'd7,          5'd3, 1'b1, 1'b0};
    t_exp[1]  = {4'd2,  32'd9,          32'd4,          5'd3, 1'b1, 1'b0};
    t_exp[2]  = {4'd9,  32'h80000000,   32'd3,          5'd5, 1'b1, 1'b0};
    t_exp[3]  = {4'd1,  32'd0,          32'h12345000,   5'd1, 1'b1, 1'b0};
    t_exp[4]  = {4'd0,  32'd0,          32'd0,          5'd0, 1'b0, 1'b1};
    t_exp[5]  = {4'd1,  32'h2000,       32'h1000,       5'd2, 1'b1, 1'b0};
    t_exp[6]  = {4'd1,  32'h100,        32'd8,          5'd8, 1'b0, 1'b0};
    t_exp[7]  = {4'd1,  32'h55,         32'hFFFFFFFF,   5'd0, 1'b0, 1'b0};
    t_exp[8]  = {4'd0,  32'd0,          32'd0,          5'd0, 1'b0, 1'b1};
    t_exp[9]  = {4'd0,  32'd0,          32'd0,          5'd0, 1'b0, 1'b1};
    t_exp[10] = {4'd0,  32'd0,          32'd0,          5'd0, 1'b0, 1'b1};
    t_exp[11] = {4'd5,  32'hA0,         32'h400,        5'd1, 1'b1, 1'b0};
    bus.out_ready = 1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i-1, bus.out_valid); end
        checks++; if (obs_now() !== t_exp[i-1]) begin errors++; $display("FAIL b2b_decode[%0d] got=%h exp=%h", i-1, obs_now(), t_exp[i-1]); end
      end
      if (i < 12) drive(1, t_ins[i], t_pc[i], t_r1[i], t_r2[i]);
      else        drive(0, 0, 0, 0, 0);
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t ea, eb;
    ea = {4'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    eb = {4'd2, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0};
    @(negedge clk);
    bus.out_ready = 1; drive(1, 32'h002081B3, 0, 5, 7);
    @(negedge clk);
    bus.out_ready = 0; drive(1, 32'h402081B3, 0, 9, 4);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got=%b exp=0", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", c, bus.out_valid); end
      checks++; if (obs_now() !== ea) begin errors++; $display("FAIL bp_hold_data[%0d] got=%h exp=%h", c, obs_now(), ea); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, bus.in_ready); end
    end
    bus.out_ready = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%b exp=1", bus.out_valid); end
    checks++; if (obs_now() !== eb) begin errors++; $display("FAIL bp_second_data got=%h exp=%h", obs_now(), eb); end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.out_ready = 0; drive(1, 32'h002081B3, 0, 5, 7);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got=%b exp=1", bus.out_valid); end
    bus.flush = 1; drive(1, 32'h402081B3, 0, 9, 4);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    bus.flush = 0; drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", bus.out_valid); end
    drive(1, 32'h0000007F, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_illegal !== 1'b1) begin errors++; $display("FAIL flush_pre_illegal got=%b exp=1", bus.out_illegal); end
    bus.flush = 1; drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL flush_illegal got=%b exp=0", bus.out_illegal); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_illegal_valid got=%b exp=0", bus.out_valid); end
    bus.flush = 0;
  endtask

  task automatic test_async_reset();
    exp_t zero;
    zero = '0;
    @(negedge clk);
    bus.out_ready = 0; drive(1, 32'h002081B3, 0, 5, 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (obs_now() !== zero) begin errors++; $display("FAIL arst_outputs got=%h exp=%h", obs_now(), zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    logic [31:0] e1_hit, e1_cap, e2_hit;
`ifdef ALU_ISSUE_BYPASS_EN
    e1_hit = 32'hDEAD; e2_hit = 32'h1234; e1_cap = 32'hCAFE;
`else
    e1_hit = 32'd5;    e2_hit = 32'd7;    e1_cap = 32'd5;
`endif
    @(negedge clk);
    bus.out_ready = 0; drive(1, 32'h002081B3, 0, 5, 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.alu_op1 !== 32'd5) begin errors++; $display("FAIL byp_pre_op1 got=%h exp=%h", bus.alu_op1, 32'd5); end
    bus.wb_en = 1; bus.wb_rd = 1; bus.wb_data = 32'hDEAD;
    @(negedge clk);
    checks++; if (bus.alu_op1 !== e1_hit) begin errors++; $display("FAIL byp_hold_op1 got=%h exp=%h", bus.alu_op1, e1_hit); end
    bus.wb_rd = 0; bus.wb_data = 32'hBEEF;
    @(negedge clk);
    checks++; if (bus.alu_op1 !== e1_hit) begin errors++; $display("FAIL byp_x0_op1 got=%h exp=%h", bus.alu_op1, e1_hit); end
    bus.wb_rd = 2; bus.wb_data = 32'h1234;
    @(negedge clk);
    checks++; if (bus.alu_op2 !== e2_hit) begin errors++; $display("FAIL byp_hold_op2 got=%h exp=%h", bus.alu_op2, e2_hit); end
    checks++; if (bus.alu_op1 !== e1_hit) begin errors++; $display("FAIL byp_op1_kept got=%h exp=%h", bus.alu_op1, e1_hit); end
    bus.out_ready = 1; bus.wb_rd = 1; bus.wb_data = 32'hCAFE;
    drive(1, 32'h002081B3, 0, 5, 7);
    @(negedge clk);
    checks++; if (bus.alu_op1 !== e1_cap) begin errors++; $display("FAIL byp_capture_op1 got=%h exp=%h", bus.alu_op1, e1_cap); end
    checks++; if (bus.alu_op2 !== 32'd7) begin errors++; $display("FAIL byp_capture_op2 got=%h exp=%h", bus.alu_op2, 32'd7); end
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  // Random traffic with random stalls and flushes, checked against a one-entry holding model.
  task automatic test_random();
    exp_t m;
    logic m_vld;
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    bus.flush = 0; bus.out_ready = 0; bus.wb_en = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m = '0; m_vld = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== m_vld) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, bus.out_valid, m_vld); end
      checks++; if (obs_now() !== m) begin errors++; $display("FAIL rnd_outputs[%0d] got=%h exp=%h", c, obs_now(), m); end
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (bus.in_ready !== (!m_vld || bus.out_ready)) begin errors++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", c, bus.in_ready, (!m_vld || bus.out_ready)); end
      if (bus.flush) begin
        m_vld = 0; m.ill = 0;
      end else if (bus.in_valid && (!m_vld || bus.out_ready)) begin
        m = model_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data); m_vld = 1;
      end else if (bus.out_ready) begin
        m_vld = 0;
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    bus.flush = 0; bus.out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX stage directly upstream of the execute ALU.
- Decodes a 32-bit RV32I instruction into the ALU's 4-bit func code and selects and registers op1/op2, so the ALU sees stable operands one cycle later.
- Uses a valid/ready handshake on both sides and supports pipeline flush.
- The ALU's result consumer (EX/MEM) back-pressures through out_ready.

Parameters:
- DATA_WIDTH, 32, operand and result width (must be 32 for RV32I immediates).
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction and operands present.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  raw instruction word.
- pc  input  DATA_WIDTH  instruction address.
- rs1_data  input  DATA_WIDTH  register-file read of instr[19:15].
- rs2_data  input  DATA_WIDTH  register-file read of instr[24:20].
- flush  input  1  kill the held and the incoming instruction.
- out_valid  output  1  registered op is valid.
- out_ready  input  1  downstream accepts.
- alu_func  output  4  ALU code: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10.
- alu_op1  output  DATA_WIDTH  first operand.
- alu_op2  output  DATA_WIDTH  second operand.
- out_rd  output  REG_ADDR_W  destination register.
- out_wb_en  output  1  result is written back (0 for stores, illegal, and rd=0).
- out_illegal  output  1  undecodable instruction.
- wb_en, wb_rd, wb_data  input  1/5/DATA_WIDTH  writeback bypass (used only with the optional feature).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_func=0, alu_op1=0, alu_op2=0, out_rd=0, out_wb_en=0, out_illegal=0.
- Handshake: in_ready = !out_valid || out_ready, computed combinationally.
  - Capture on in_valid && in_ready && !flush.
  - Latency is 1 cycle; full throughput with no bubbles.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Transfer: when out_ready=1 and there is no new capture, out_valid clears.
- Flush: synchronous and highest priority. The next edge forces out_valid=0 and out_illegal=0, and drops any incoming instruction that cycle.
- Decode for OP (0110011):
  - f3 000: ADD if instr[30]=0, SUB if instr[30]=1.
  - f3 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - f3 101: SRL or SRA by instr[30].
  - f3 110: OR. 111: AND.
  - funct7 other than 0000000 is illegal, except 0100000 with f3 000/101.
  - op1=rs1_data, op2=rs2_data.
- Decode for OP-IMM (0010011):
  - Same f3 mapping, but f3 000 is always ADD.
  - Shifts use op2 = zero-extended instr[24:20].
  - SLLI requires instr[31:25]=0; SRLI/SRAI require instr[31:25] of 0000000 or 0100000; otherwise illegal.
  - Non-shifts use op2 = sign-extended instr[31:20]. op1=rs1_data.
- Decode for LUI (0110111): ADD, op1=0, op2={instr[31:12],12'b0}.
- Decode for AUIPC (0010111): ADD, op1=pc, same op2 as LUI.
- Decode for LOAD (0000011): ADD, op1=rs1_data, op2=I-immediate.
- Decode for STORE (0100011): ADD, op1=rs1_data, op2=sign-extended {instr[31:25],instr[11:7]}, out_wb_en=0.
- Any other opcode, or instr[1:0]!=11: out_illegal=1, alu_func=ZERO, op1=op2=0, out_wb_en=0. The instruction still passes through the handshake.
- rd=0 forces out_wb_en=0. out_rd always carries instr[11:7], or 0 when illegal.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined:
  - At capture, if wb_en && wb_rd!=0 && wb_rd matches rs1/rs2 of the captured instruction and that operand comes from the register file, wb_data replaces rs1_data/rs2_data.
  - While holding (out_valid && !out_ready), a matching writeback updates the held register-sourced operand in place. Source indices are kept internally for this.
- Undefined: wb_* ports are present but ignored; operands come only from rs1_data/rs2_data.

Test Plan:
- ADD: instr 0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, func=1, op1=5, op2=7, out_rd=3, out_wb_en=1.
- SUB and SRAI:
  - 0x402081B3 -> func=2.
  - 0x40335293 with rs1=0x80000000 -> func=9, op1=0x80000000, op2=3, rd=5.
- LUI: 0x123450B7 -> func=1, op1=0, op2=0x12345000, rd=1. Illegal case: 0x0000007F -> out_illegal=1, func=0, out_wb_en=0.
- Back-pressure: out_ready=0 for 3 cycles with a second instruction offered -> in_ready=0, outputs unchanged. Then out_ready=1 -> second instruction appears the next cycle with no loss or duplication.
- Flush: flush=1 together with in_valid=1 while holding a valid op -> next cycle out_valid=0, incoming instruction dropped. Async rst_n low mid-hold -> all outputs 0 immediately.
- Bypass (ALU_ISSUE_BYPASS_EN): hold ADD x3,x1,x2 stalled, then wb_en=1, wb_rd=1, wb_data=0xDEAD -> op1=0xDEAD. Same stimulus with wb_rd=0 -> op1 unchanged.
